fifo_read_streamer: RTL and testbench

//  Read-side controller for the 8-bit fifo_memory: on a start command it drains

---
 rtl/fifo_read_streamer_if.sv | 22 ++
 rtl/fifo_read_streamer.sv | 109 ++++++++++
 tb/tb_fifo_read_streamer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_streamer_if.sv
// FIFO read port and output stream of fifo_read_streamer.
// master = streamer side, slave = FIFO/consumer side.
interface fifo_read_streamer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output read_enable, out_data, out_valid
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  read_enable, out_data, out_valid
    );
endinterface

// File: rtl/fifo_read_streamer.sv
// Drains burst_len words from a latency-1 FIFO into a valid/ready stream,
// issuing reads only while the 2-entry skid buffer has credit for them.
module fifo_read_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] burst_len,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_WIDTH-1:0] words_left,
    fifo_read_streamer_if.master rd
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  words_left_q, words_left_d;
    logic                  inflight_q;
    logic [1:0]            occ_q, occ_d;
    logic                  head_q, head_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic                  zero_done_q, zero_done_d;

    logic rd_en;
    logic xfer;
    logic credit_ok;
    logic drain_done;

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        occ_d        = occ_q;
        head_d       = head_q;
        buf_d        = buf_q;
        zero_done_d  = 1'b0;
        drain_done   = 1'b0;

        xfer = (occ_q != 2'd0) & rd.out_ready;
        // A word leaving this cycle frees its slot for a read issued this cycle.
        credit_ok = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, xfer});
        rd_en = (state_q == READ) & ~rd.fifo_empty & (words_left_q != '0) & credit_ok;

        if (inflight_q) begin
            buf_d[head_q ^ occ_q[0]] = rd.fifo_data;
        end
        head_d = head_q ^ xfer;
        occ_d  = occ_q + {1'b0, inflight_q} - {1'b0, xfer};

        if (rd_en) begin
            words_left_d = words_left_q - 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        state_d      = READ;
                        words_left_d = burst_len;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (rd_en && (words_left_q == LEN_WIDTH'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight_q && (occ_q == 2'd0)) begin
                    state_d    = IDLE;
                    drain_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            words_left_q <= '0;
            inflight_q   <= 1'b0;
            occ_q        <= '0;
            head_q       <= 1'b0;
            buf_q[0]     <= '0;
            buf_q[1]     <= '0;
            zero_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            inflight_q   <= rd_en;
            occ_q        <= occ_d;
            head_q       <= head_d;
            buf_q        <= buf_d;
            zero_done_q  <= zero_done_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = zero_done_q | drain_done;
    assign words_left     = words_left_q;
    assign rd.read_enable = rd_en;
    assign rd.out_valid   = (occ_q != 2'd0);
    assign rd.out_data    = buf_q[head_q];
endmodule

// File: tb/tb_fifo_read_streamer.sv
// Directed bench for fifo_read_streamer with a behavioural latency-1 FIFO.
module tb_fifo_read_streamer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] burst_len = '0;
    logic       busy, done;
    logic [7:0] words_left;

    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       force_empty = 1'b0;
    logic [7:0] mem [256];
    logic [7:0] wr_ptr, rd_ptr;

    int tests = 0;
    int fails = 0;

    int         rd_cnt = 0, done_cnt = 0, busy_cnt = 0, empty_viol = 0;
    logic [7:0] rx [$];

    fifo_read_streamer_if #(.DATA_WIDTH(8)) bus ();

    fifo_read_streamer #(.DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .burst_len  (burst_len),
        .busy       (busy),
        .done       (done),
        .words_left (words_left),
        .rd         (bus)
    );

    always #5 clk = ~clk;

    assign bus.fifo_empty = (wr_ptr == rd_ptr) | force_empty;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            bus.fifo_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 8'd1;
            end
            if (bus.read_enable && !bus.fifo_empty) begin
                bus.fifo_data <= mem[rd_ptr];
                rd_ptr        <= rd_ptr + 8'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.read_enable) rd_cnt++;
            if (bus.read_enable && bus.fifo_empty) empty_viol++;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (bus.out_valid && bus.out_ready) rx.push_back(bus.out_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic kick(input logic [7:0] len);
        start     = 1'b1;
        burst_len = len;
        cycles(1);
        start     = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        cycles(1);
        wr_en   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input int budget);
        int n;
        n = 0;
        while (done_cnt == base && n < budget) begin
            cycles(1);
            n++;
        end
        check(tag, 32'(done_cnt == base), 32'd0);
        cycles(1);
    endtask

    initial begin
        int rb, db, bb, errs;
        logic [9:0]  re_v, ov_v, dn_v, bz_v;
        logic [31:0] od_v;
        logic [7:0]  exp_q [$];
        int          pushed, n;

        bus.out_ready = 1'b1;
        #23 reset_n = 1'b1;
        cycles(1);
        check("reset_outputs", {busy, done, words_left, bus.read_enable, bus.out_valid, bus.out_data},
              32'd0);

        // Reset mid-burst
        for (int i = 1; i <= 5; i++) push(8'(i));
        rb = rd_cnt;
        kick(8'd5);
        n = 0;
        while (rd_cnt - rb < 3 && n < 20) begin
            cycles(1);
            n++;
        end
        check("mid_reads_timeout", 32'(rd_cnt - rb < 3), 32'd0);
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {busy, done, words_left, bus.read_enable, bus.out_valid, bus.out_data}, 32'd0);
        cycles(1);
        reset_n = 1'b1;
        cycles(1);
        check("post_reset_idle", {busy, words_left}, 32'd0);

        // Back-to-back burst of 4
        bus.out_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        kick(8'd4);
        re_v = '0; ov_v = '0; dn_v = '0; bz_v = '0; od_v = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            re_v[i] = bus.read_enable;
            ov_v[i] = bus.out_valid;
            dn_v[i] = done;
            bz_v[i] = busy;
            if (i >= 2 && i <= 5) od_v = {od_v[23:0], bus.out_data};
        end
        #6;
        check("b2b_read_enable", 32'(re_v), 32'b0000001111);
        check("b2b_out_valid", 32'(ov_v), 32'b0000111100);
        check("b2b_data", od_v, 32'h11223344);
        check("b2b_done", 32'(dn_v), 32'b0001000000);
        check("b2b_busy", 32'(bz_v), 32'b0001111111);

        // Backpressure
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(8'h50 + 8'(i));
        rb = rd_cnt; bb = rx.size(); db = done_cnt;
        kick(8'd5);
        cycles(8);
        check("bp_reads", 32'(rd_cnt - rb), 32'd2);
        check("bp_hold", {bus.read_enable, bus.out_valid, bus.out_data, words_left}, {16'd0, 1'b0, 1'b1, 8'h51, 8'd3});
        bus.out_ready = 1'b1;
        wait_done("bp_done_timeout", db, 60);
        check("bp_count", 32'(rx.size() - bb), 32'd5);
        errs = 0;
        for (int i = 0; i < 5; i++)
            if (rx.size() > bb + i && rx[bb + i] !== 8'h51 + 8'(i)) errs++;
        check("bp_order", 32'(errs), 32'd0);

        // Empty stall
        rb = rd_cnt; bb = rx.size(); db = done_cnt;
        kick(8'd3);
        cycles(4);
        check("stall_no_read", 32'(rd_cnt - rb), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        push(8'hA5);
        cycles(4);
        check("stall_one_read", 32'(rd_cnt - rb), 32'd1);
        check("stall_data", 32'(rx.size() > bb ? rx[bb] : 8'h00), 32'hA5);
        check("stall_words_left", 32'(words_left), 32'd2);
        push(8'hB6); push(8'hC7);
        wait_done("stall_done_timeout", db, 40);
        check("stall_count", 32'(rx.size() - bb), 32'd3);

        // Zero-length burst and start while busy
        db = done_cnt; bb = busy_cnt;
        kick(8'd0);
        cycles(3);
        check("zero_done_once", 32'(done_cnt - db), 32'd1);
        check("zero_no_busy", 32'(busy_cnt - bb), 32'd0);
        rb = rx.size(); db = done_cnt;
        kick(8'd3);
        cycles(2);
        check("busy_loaded", 32'(words_left), 32'd3);
        kick(8'd9);
        cycles(2);
        check("busy_start_ignored", {busy, words_left}, {23'd0, 1'b1, 8'd3});
        push(8'h01); push(8'h02); push(8'h03);
        wait_done("ign_done_timeout", db, 40);
        check("ign_count", 32'(rx.size() - rb), 32'd3);

        // Random gaps and backpressure, 200 words
        bb = rx.size(); db = done_cnt; pushed = 0; n = 0;
        kick(8'd200);
        while (done_cnt == db && n < 4000) begin
            if (pushed < 200 && $urandom_range(0, 2) != 0) begin
                wr_en   = 1'b1;
                wr_data = 8'($urandom);
                exp_q.push_back(wr_data);
                pushed++;
            end else begin
                wr_en = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            force_empty   = ($urandom_range(0, 4) == 0);
            cycles(1);
            n++;
        end
        wr_en = 1'b0; force_empty = 1'b0; bus.out_ready = 1'b1;
        check("rand_done_timeout", 32'(done_cnt == db), 32'd0);
        check("rand_count", 32'(rx.size() - bb), 32'd200);
        errs = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (rx.size() <= bb + i || rx[bb + i] !== exp_q[i]) errs++;
        check("rand_order", 32'(errs), 32'd0);
        check("read_when_empty", 32'(empty_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
